// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame layout, FSM state
// encoding and the odd-parity rule used when a frame is closed.
package ps2_pkg;

    // Number of data bits carried by one PS/2 frame.
    localparam int PS2_DATA_BITS = 8;

    // Bit counter must be able to hold 0..PS2_DATA_BITS.
    localparam int PS2_BIT_CNT_W = $clog2(PS2_DATA_BITS + 1);

    // Frame FSM states. Plain constants keep the encoding stable for
    // older tools and for anyone probing the state vector on a scope.
    localparam int          PS2_STATE_W = 2;
    localparam logic [1:0]  IDLE        = 2'd0;
    localparam logic [1:0]  DATA        = 2'd1;
    localparam logic [1:0]  PARITY      = 2'd2;
    localparam logic [1:0]  STOP        = 2'd3;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(
        input logic [PS2_DATA_BITS-1:0] data,
        input logic                     parity
    );
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Byte-level interface between the PS/2 frame receiver and the scan-code
// decoder. The receiver is the master: it drives the received byte and the
// status strobes, and the decoder side supplies the receive enable.
interface ps2_rx_frame_if;
    import ps2_pkg::*;

    logic                     rx_en;
    logic [PS2_DATA_BITS-1:0] data_out;
    logic                     valid;
    logic                     parity_err;
    logic                     frame_err;
    logic                     timeout_err;
    logic                     busy;

    modport master (
        input  rx_en,
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output timeout_err,
        output busy
    );

    modport slave (
        output rx_en,
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  timeout_err,
        input  busy
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Brings the raw PS/2 clock and data lines into the system clock domain,
// deglitches the PS/2 clock and flags each falling edge of the cleaned
// clock together with the data bit that belongs to it.
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_bit
);

    // Counter must reach FILTER_LEN-1; FILTER_LEN below 2 is not meaningful.
    localparam int              CNT_W    = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             clk_s1;
    logic             clk_s2;
    logic             data_s1;
    logic             data_s2;
    logic             filt;
    logic             filt_prev;
    logic [CNT_W-1:0] filt_cnt;

    // Two-flop synchronisers; preset high so reset looks like an idle bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive opposite samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CNT_LAST) begin
            filt     <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Delayed copy of the filtered clock for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_prev <= 1'b1;
        end else begin
            filt_prev <= filt;
        end
    end

    assign fall     = filt_prev & ~filt;
    assign data_bit = data_s2;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framing controller. Walks the 11-bit frame (start, 8 data
// bits LSB first, odd parity, stop) on falling edges of the cleaned PS/2
// clock, abandons stalled frames, and reports each frame's outcome with a
// single-cycle strobe.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_rx_frame_if.master bus
);

    localparam int                        TO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]           TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [PS2_BIT_CNT_W-1:0]  LAST_BIT = PS2_BIT_CNT_W'(PS2_DATA_BITS - 1);

    logic                     fall;
    logic                     data_bit;
    logic [PS2_STATE_W-1:0]   state;
    logic [PS2_BIT_CNT_W-1:0] bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift_reg;
    logic                     parity_bit;
    logic [TO_W-1:0]          to_cnt;
    logic                     to_hit;
    logic [PS2_DATA_BITS-1:0] data_q;
    logic                     valid_q;
    logic                     parity_err_q;
    logic                     frame_err_q;
    logic                     timeout_err_q;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_bit (data_bit)
    );

    // A fall arriving in the same cycle as the timeout keeps the frame alive.
    assign to_hit = (state != IDLE) && (to_cnt == TO_LAST) && !fall;

    // Frame FSM with the LSB-first shift register and bit counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else if (!bus.rx_en) begin
            state <= IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_bit) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shift_reg <= {data_bit, shift_reg[PS2_DATA_BITS-1:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    parity_bit <= data_bit;
                    state      <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end else if (to_hit) begin
            state <= IDLE;
        end
    end

    // Inter-edge watchdog: counts only while a frame is open, restarts on each fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (!bus.rx_en || (state == IDLE) || fall) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Registered byte output and one-cycle outcome strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q        <= '0;
            valid_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            valid_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            if (bus.rx_en) begin
                if (fall && (state == STOP)) begin
                    if (!data_bit) begin
                        frame_err_q <= 1'b1;
                    end else if (odd_parity_ok(shift_reg, parity_bit)) begin
                        data_q  <= shift_reg;
                        valid_q <= 1'b1;
                    end else begin
                        parity_err_q <= 1'b1;
                    end
                end else if (to_hit) begin
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.valid       = valid_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame. PS/2 frames are bit-banged onto the
// raw lines; the outcome of each frame is predicted from the frame rules
// (odd parity, stop bit) and compared against the strobes seen on the bus.
module tb_ps2_rx_frame;

    // Shortened timeout and PS/2 bit period keep the run to a few tens of
    // thousands of cycles while keeping the same relative timing.
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 3000;
    localparam int HALF        = 40;
    localparam int LAT_MIN     = FILTER_LEN + 2;
    localparam int LAT_MAX     = FILTER_LEN + 4;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_fall_cyc = 0;

    int mon_valid    = 0;
    int mon_perr     = 0;
    int mon_ferr     = 0;
    int mon_terr     = 0;
    int mon_multi    = 0;
    int mon_wide     = 0;
    int mon_evt_cyc  = 0;
    int mon_terr_cyc = 0;
    logic [3:0] mon_flags;
    logic [3:0] prev_flags = 4'b0;

    logic [7:0] exp_data = 8'h00;

    ps2_rx_frame_if bus ();

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.master)
    );

    // System clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampling on the falling system-clock edge.
    always @(negedge clk) begin
        mon_flags = {bus.valid, bus.parity_err, bus.frame_err, bus.timeout_err};
        if ($countones(mon_flags) > 1) mon_multi++;
        if ((mon_flags & prev_flags) != 4'b0) mon_wide++;
        prev_flags = mon_flags;
        if (bus.valid === 1'b1)       mon_valid++;
        if (bus.parity_err === 1'b1)  mon_perr++;
        if (bus.frame_err === 1'b1)   mon_ferr++;
        if (bus.timeout_err === 1'b1) begin
            mon_terr++;
            mon_terr_cyc = cyc;
        end
        if (mon_flags != 4'b0) mon_evt_cyc = cyc;
    end

    // Reference rule: 0 = good byte, 1 = parity error, 2 = framing error.
    function automatic int model_outcome(input logic [7:0] d, input logic p, input logic s);
        if (s == 1'b0) return 2;
        if ((($countones(d) + int'(p)) % 2) == 1) return 0;
        return 1;
    endfunction

    // One PS/2 bit cell: data settles, clock high, clock low, clock high.
    task automatic ps2_bit(input logic b, input logic glitch);
        @(negedge clk);
        ps2_data = b;
        if (glitch) begin
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 10 - (FILTER_LEN - 1)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame and reports the strobes it produced.
    task automatic do_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input int glitch_bit,
                            output int dv, output int dp, output int df,
                            output int dt, output int lat);
        logic [10:0] bits;
        int v0, p0, f0, t0;
        bits = {s, p, d, 1'b0};
        v0 = mon_valid;
        p0 = mon_perr;
        f0 = mon_ferr;
        t0 = mon_terr;
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], (i == glitch_bit));
        repeat (30) @(negedge clk);
        dv  = mon_valid - v0;
        dp  = mon_perr - p0;
        df  = mon_ferr - f0;
        dt  = mon_terr - t0;
        lat = mon_evt_cyc - last_fall_cyc;
    endtask

    task automatic test_reset();
        bus.rx_en = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_out: got %0h expected 00", bus.data_out); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.valid); end
        checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity_err: got %0b expected 0", bus.parity_err); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %0b expected 0", bus.frame_err); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err: got %0b expected 0", bus.timeout_err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
        reset = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_framing();
        logic [7:0] td [4];
        logic       tp [4];
        logic       ts [4];
        int dv, dp, df, dt, lat, oc;
        td[0] = 8'h1C; tp[0] = 1'b0; ts[0] = 1'b1;
        td[1] = 8'hF0; tp[1] = 1'b0; ts[1] = 1'b1;
        td[2] = 8'h5A; tp[2] = 1'b1; ts[2] = 1'b0;
        td[3] = 8'h5A; tp[3] = 1'b1; ts[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_frame(td[i], tp[i], ts[i], 11, -1, dv, dp, df, dt, lat);
            oc = model_outcome(td[i], tp[i], ts[i]);
            if (oc == 0) exp_data = td[i];
            checks++; if (dv != int'(oc == 0)) begin failures++; $display("[TB] FAIL framing_valid[%0d]: got %0d expected %0d", i, dv, int'(oc == 0)); end
            checks++; if (dp != int'(oc == 1)) begin failures++; $display("[TB] FAIL framing_parity_err[%0d]: got %0d expected %0d", i, dp, int'(oc == 1)); end
            checks++; if (df != int'(oc == 2)) begin failures++; $display("[TB] FAIL framing_frame_err[%0d]: got %0d expected %0d", i, df, int'(oc == 2)); end
            checks++; if (dt != 0) begin failures++; $display("[TB] FAIL framing_timeout_err[%0d]: got %0d expected 0", i, dt); end
            checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL framing_data_out[%0d]: got %0h expected %0h", i, bus.data_out, exp_data); end
            checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin failures++; $display("[TB] FAIL framing_latency[%0d]: got %0d expected %0d..%0d", i, lat, LAT_MIN, LAT_MAX); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL framing_busy[%0d]: got %0b expected 0", i, bus.busy); end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic p, s;
        int dv, dp, df, dt, lat, oc;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 3) == 0) ? (^d) : ~(^d);
            s = ($urandom_range(0, 5) != 0);
            do_frame(d, p, s, 11, -1, dv, dp, df, dt, lat);
            oc = model_outcome(d, p, s);
            if (oc == 0) exp_data = d;
            checks++; if ({dv, dp, df, dt} != {int'(oc == 0), int'(oc == 1), int'(oc == 2), 0}) begin
                failures++;
                $display("[TB] FAIL random_outcome[%0d] d=%0h p=%0b s=%0b: got v/p/f/t=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/0",
                         i, d, p, s, dv, dp, df, dt, int'(oc == 0), int'(oc == 1), int'(oc == 2));
            end
            checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL random_data_out[%0d]: got %0h expected %0h", i, bus.data_out, exp_data); end
        end
    endtask

    task automatic test_timeout();
        int dv, dp, df, dt, lat, t0, v0, waited, delta;
        t0 = mon_terr;
        v0 = mon_valid + mon_perr + mon_ferr;
        do_frame(8'hA5, 1'b1, 1'b1, 5, -1, dv, dp, df, dt, lat);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL timeout_busy_mid: got %0b expected 1", bus.busy); end
        waited = 0;
        while (mon_terr == t0 && waited < TIMEOUT_CYC + 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        delta = mon_terr_cyc - last_fall_cyc;
        checks++; if (mon_terr - t0 != 1) begin failures++; $display("[TB] FAIL timeout_pulse: got %0d expected 1", mon_terr - t0); end
        checks++; if (delta < TIMEOUT_CYC + LAT_MIN - 1 || delta > TIMEOUT_CYC + LAT_MAX - 1) begin
            failures++; $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d", delta, TIMEOUT_CYC + LAT_MIN - 1, TIMEOUT_CYC + LAT_MAX - 1);
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy_after: got %0b expected 0", bus.busy); end
        checks++; if (mon_valid + mon_perr + mon_ferr != v0) begin failures++; $display("[TB] FAIL timeout_other_pulses: got %0d expected %0d", mon_valid + mon_perr + mon_ferr, v0); end
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL timeout_data_hold: got %0h expected %0h", bus.data_out, exp_data); end
        do_frame(8'h29, 1'b0, 1'b1, 11, -1, dv, dp, df, dt, lat);
        exp_data = 8'h29;
        checks++; if (dv != 1 || dp + df + dt != 0) begin failures++; $display("[TB] FAIL timeout_recover: got v=%0d errs=%0d expected v=1 errs=0", dv, dp + df + dt); end
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL timeout_recover_data: got %0h expected %0h", bus.data_out, exp_data); end
    endtask

    task automatic test_glitch();
        int dv, dp, df, dt, lat, e0;
        e0 = mon_valid + mon_perr + mon_ferr + mon_terr;
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_idle_busy: got %0b expected 0", bus.busy); end
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (mon_valid + mon_perr + mon_ferr + mon_terr != e0) begin failures++; $display("[TB] FAIL glitch_idle_pulses: got %0d expected %0d", mon_valid + mon_perr + mon_ferr + mon_terr, e0); end
        do_frame(8'h1C, 1'b0, 1'b1, 11, 4, dv, dp, df, dt, lat);
        exp_data = 8'h1C;
        checks++; if (dv != 1 || dp + df + dt != 0) begin failures++; $display("[TB] FAIL glitch_data_outcome: got v=%0d errs=%0d expected v=1 errs=0", dv, dp + df + dt); end
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL glitch_data_out: got %0h expected %0h", bus.data_out, exp_data); end
    endtask

    task automatic test_reset_abort();
        int dv, dp, df, dt, lat, e0;
        do_frame(8'h1C, 1'b0, 1'b1, 6, -1, dv, dp, df, dt, lat);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_abort_busy_mid: got %0b expected 1", bus.busy); end
        e0 = mon_valid + mon_perr + mon_ferr + mon_terr;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_data = 8'h00;
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL rst_abort_data_out: got %0h expected %0h", bus.data_out, exp_data); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_abort_busy: got %0b expected 0", bus.busy); end
        repeat (20) @(negedge clk);
        checks++; if (mon_valid + mon_perr + mon_ferr + mon_terr != e0) begin failures++; $display("[TB] FAIL rst_abort_pulses: got %0d expected %0d", mon_valid + mon_perr + mon_ferr + mon_terr, e0); end
        do_frame(8'h1C, 1'b0, 1'b1, 11, -1, dv, dp, df, dt, lat);
        exp_data = 8'h1C;
        checks++; if (dv != 1 || dp + df + dt != 0) begin failures++; $display("[TB] FAIL rst_abort_recover: got v=%0d errs=%0d expected v=1 errs=0", dv, dp + df + dt); end
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL rst_abort_recover_data: got %0h expected %0h", bus.data_out, exp_data); end
    endtask

    task automatic test_rx_en_abort();
        int dv, dp, df, dt, lat, e0;
        do_frame(8'h1C, 1'b0, 1'b1, 4, -1, dv, dp, df, dt, lat);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL rxen_busy_mid: got %0b expected 1", bus.busy); end
        e0 = mon_valid + mon_perr + mon_ferr + mon_terr;
        @(negedge clk);
        bus.rx_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rxen_busy_off: got %0b expected 0", bus.busy); end
        repeat (3) @(negedge clk);
        bus.rx_en = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (mon_valid + mon_perr + mon_ferr + mon_terr != e0) begin failures++; $display("[TB] FAIL rxen_pulses: got %0d expected %0d", mon_valid + mon_perr + mon_ferr + mon_terr, e0); end
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL rxen_data_hold: got %0h expected %0h", bus.data_out, exp_data); end
        do_frame(8'h1C, 1'b0, 1'b1, 11, -1, dv, dp, df, dt, lat);
        exp_data = 8'h1C;
        checks++; if (dv != 1 || dp + df + dt != 0) begin failures++; $display("[TB] FAIL rxen_recover: got v=%0d errs=%0d expected v=1 errs=0", dv, dp + df + dt); end
        checks++; if (bus.data_out !== exp_data) begin failures++; $display("[TB] FAIL rxen_recover_data: got %0h expected %0h", bus.data_out, exp_data); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (mon_multi != 0) begin failures++; $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles expected 0", mon_multi); end
        checks++; if (mon_wide != 0) begin failures++; $display("[TB] FAIL pulse_width: got %0d over-long pulses expected 0", mon_wide); end
    endtask

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected completion within time limit");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        test_reset();
        test_framing();
        test_random_frames();
        test_timeout();
        test_glitch();
        test_reset_abort();
        test_rx_en_abort();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
